// File: rtl/raw_bayer_unpacker.sv
// Raw SD-card frame unpacker: strips frame/row headers and trailers and maps Bayer samples to RGB565.
// Optional statistics ports are enabled by defining RAW_UNPACK_STATS_EN.
module raw_bayer_unpacker #(
    parameter int DATA_W         = 16,
    parameter int COLS           = 1920,
    parameter int ROWS           = 1080,
    parameter int FRAME_HEAD_NUM = 7744,
    parameter int FRAME_TAIL_NUM = 7744,
    parameter int ROW_HEAD_NUM   = 8,
    parameter int ROW_TAIL_NUM   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic [1:0]        cfg_bayer,
    input  logic [3:0]        cfg_shift,
    input  logic              frame_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [15:0]       out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done
`ifdef RAW_UNPACK_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [31:0]       stat_pixels
`endif
);

    localparam int MAX_HT_A  = (FRAME_HEAD_NUM > FRAME_TAIL_NUM) ? FRAME_HEAD_NUM : FRAME_TAIL_NUM;
    localparam int MAX_HT_B  = (ROW_HEAD_NUM > ROW_TAIL_NUM) ? ROW_HEAD_NUM : ROW_TAIL_NUM;
    localparam int MAX_HT    = (MAX_HT_A > MAX_HT_B) ? MAX_HT_A : MAX_HT_B;
    localparam int CNT_W     = (MAX_HT > 1) ? $clog2(MAX_HT) : 1;
    localparam int COL_W     = $clog2(COLS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int SHIFT_MAX = DATA_W - 6;

    localparam logic [CNT_W-1:0] FH_LAST  = CNT_W'(FRAME_HEAD_NUM - 1);
    localparam logic [CNT_W-1:0] FT_LAST  = CNT_W'(FRAME_TAIL_NUM - 1);
    localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(ROW_HEAD_NUM - 1);
    localparam logic [CNT_W-1:0] RT_LAST  = CNT_W'(ROW_TAIL_NUM - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        F_HEAD = 3'd0,
        R_HEAD = 3'd1,
        R_DATA = 3'd2,
        R_TAIL = 3'd3,
        F_TAIL = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             rowpar_r;
    logic             cfg_load_r;
    logic [1:0]       cfg_mode_r;
    logic [1:0]       cfg_bayer_r;
    logic [3:0]       cfg_shift_r;

    logic [31:0]      eff_shift_s;
    logic [5:0]       g6_s;
    logic [4:0]       c5_s;
    logic             rsel_s;
    logic             csel_s;
    logic [15:0]      pix_s;
    logic             pix_take_s;
    logic             frame_end_s;

    // Sample extraction and per-pixel colour/mode formatting.
    always_comb begin
        eff_shift_s = 32'd0;
        g6_s        = 6'd0;
        c5_s        = 5'd0;
        rsel_s      = 1'b0;
        csel_s      = 1'b0;
        pix_s       = 16'd0;
        if (32'(cfg_shift_r) > SHIFT_MAX) begin
            eff_shift_s = 32'(SHIFT_MAX);
        end else begin
            eff_shift_s = 32'(cfg_shift_r);
        end
        g6_s   = 6'(in_data >> eff_shift_s);
        c5_s   = g6_s[5:1];
        rsel_s = rowpar_r ^ cfg_bayer_r[1];
        csel_s = col_r[0] ^ cfg_bayer_r[0];
        case (cfg_mode_r)
            2'd1: pix_s = 16'(in_data);
            2'd2: pix_s = {c5_s, g6_s, c5_s};
            default: begin
                case ({rsel_s, csel_s})
                    2'b00:   pix_s = {c5_s, 11'd0};
                    2'b11:   pix_s = {11'd0, c5_s};
                    default: pix_s = {5'd0, g6_s, 5'd0};
                endcase
            end
        endcase
    end

    // Qualifiers shared by the FSM and the statistics counters.
    always_comb begin
        pix_take_s  = 1'b0;
        frame_end_s = 1'b0;
        if (!frame_abort && in_valid) begin
            pix_take_s  = (state_r == R_DATA);
            frame_end_s = (state_r == F_TAIL) && (cnt_r == FT_LAST);
        end else begin
            pix_take_s  = 1'b0;
            frame_end_s = 1'b0;
        end
    end

    // Frame/row sequencer with registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= F_HEAD;
            cnt_r       <= '0;
            col_r       <= '0;
            row_r       <= '0;
            rowpar_r    <= 1'b0;
            cfg_load_r  <= 1'b1;
            cfg_mode_r  <= 2'd0;
            cfg_bayer_r <= 2'd0;
            cfg_shift_r <= 4'd0;
            out_valid   <= 1'b0;
            out_data    <= 16'd0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_data   <= 16'd0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
            // Config is (re)captured whenever F_HEAD is entered, including the first cycle out of reset.
            if (cfg_load_r || frame_abort || frame_end_s) begin
                cfg_load_r  <= 1'b0;
                cfg_mode_r  <= cfg_mode;
                cfg_bayer_r <= cfg_bayer;
                cfg_shift_r <= cfg_shift;
            end
            if (frame_abort) begin
                state_r  <= F_HEAD;
                cnt_r    <= '0;
                col_r    <= '0;
                row_r    <= '0;
                rowpar_r <= 1'b0;
            end else if (in_valid) begin
                case (state_r)
                    F_HEAD: begin
                        if (cnt_r == FH_LAST) begin
                            cnt_r    <= '0;
                            rowpar_r <= 1'b0;
                            state_r  <= R_HEAD;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    R_HEAD: begin
                        if (cnt_r == RH_LAST) begin
                            cnt_r   <= '0;
                            state_r <= R_DATA;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    R_DATA: begin
                        out_valid <= 1'b1;
                        out_data  <= pix_s;
                        out_sof   <= (row_r == '0) && (col_r == '0);
                        out_eol   <= (col_r == COL_LAST);
                        if (col_r == COL_LAST) begin
                            col_r   <= '0;
                            state_r <= R_TAIL;
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                    R_TAIL: begin
                        if (cnt_r == RT_LAST) begin
                            cnt_r <= '0;
                            if (row_r == ROW_LAST) begin
                                row_r   <= '0;
                                state_r <= F_TAIL;
                            end else begin
                                row_r    <= row_r + ROW_W'(1);
                                rowpar_r <= ~rowpar_r;
                                state_r  <= R_HEAD;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    F_TAIL: begin
                        if (cnt_r == FT_LAST) begin
                            cnt_r      <= '0;
                            frame_done <= 1'b1;
                            state_r    <= F_HEAD;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_r   <= '0;
                        state_r <= F_HEAD;
                    end
                endcase
            end
        end
    end

`ifdef RAW_UNPACK_STATS_EN
    // Completed-frame and per-frame pixel counters; abort restarts only the pixel count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= 16'd0;
            stat_pixels <= 32'd0;
        end else begin
            if (frame_end_s) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (frame_abort || frame_end_s) begin
                stat_pixels <= 32'd0;
            end else if (pix_take_s) begin
                stat_pixels <= stat_pixels + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_raw_bayer_unpacker.sv
// Randomised scoreboard bench for raw_bayer_unpacker using a small frame geometry.
module tb_raw_bayer_unpacker;
    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int FH   = 2;
    localparam int FT   = 2;
    localparam int RH   = 1;
    localparam int RT   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode, cfg_bayer;
    logic [3:0]  cfg_shift;
    logic        frame_abort, in_valid;
    logic [15:0] in_data;
    logic        out_valid, out_sof, out_eol, frame_done;
    logic [15:0] out_data;
`ifdef RAW_UNPACK_STATS_EN
    logic [15:0] stat_frames;
    logic [31:0] stat_pixels;
`endif

    raw_bayer_unpacker #(
        .DATA_W(16), .COLS(COLS), .ROWS(ROWS), .FRAME_HEAD_NUM(FH),
        .FRAME_TAIL_NUM(FT), .ROW_HEAD_NUM(RH), .ROW_TAIL_NUM(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_bayer(cfg_bayer),
        .cfg_shift(cfg_shift), .frame_abort(frame_abort), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
`ifdef RAW_UNPACK_STATS_EN
        , .stat_frames(stat_frames), .stat_pixels(stat_pixels)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit checking = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        bit          sof;
        bit          eol;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          done_q[$];
    int          clr_q[$];
    logic [15:0] seen_q[$];
    logic [1:0]  m_mode, m_bayer;
    logic [3:0]  m_shift;
    int          m_frames = 0;
    int          m_pix = 0;
    logic [31:0] prev_stat_pix = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected pixel from the sample value, mosaic position and frame configuration.
    function automatic logic [15:0] model_pix(input logic [1:0] md, input logic [1:0] bay,
                                              input logic [3:0] sh, input logic [15:0] w,
                                              input int r, input int c);
        int s, v, c5, rp, cp;
        s  = (int'(sh) > 10) ? 10 : int'(sh);
        v  = int'(w >> s) % 64;
        c5 = v / 2;
        rp = (r % 2) ^ (int'(bay) / 2);
        cp = (c % 2) ^ (int'(bay) % 2);
        if (md == 2'd1) return w;
        if (md == 2'd2) return 16'(c5 * 2048 + v * 32 + c5);
        if (rp == 0 && cp == 0) return 16'(c5 * 2048);
        if (rp == 1 && cp == 1) return 16'(c5);
        return 16'(v * 32);
    endfunction

    function automatic int pick_gap(input int gm);
        if (gm == 1) return 1;
        if (gm == 2) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid    = 1'b0;
            frame_abort = 1'b0;
            in_data     = 16'($urandom);
        end
    endtask

    task automatic latch_model_cfg();
        m_mode  = cfg_mode;
        m_bayer = cfg_bayer;
        m_shift = cfg_shift;
    endtask

    task automatic send_word(input logic [15:0] w, input bit is_pix, input int r, input int c,
                             input bit last, input int gap);
        exp_t e;
        if (gap > 0) idle(gap);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        frame_abort = 1'b0;
        in_data     = w;
        if (is_pix) begin
            e.d   = model_pix(m_mode, m_bayer, m_shift, w, r, c);
            e.sof = (r == 0 && c == 0);
            e.eol = (c == COLS - 1);
            e.at  = cyc + 1;
            exp_q.push_back(e);
        end
        if (last) begin
            done_q.push_back(cyc + 1);
            latch_model_cfg();
        end
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        in_valid    = 1'($urandom);
        in_data     = 16'($urandom);
        frame_abort = 1'b1;
        clr_q.push_back(cyc + 1);
        latch_model_cfg();
        idle(1);
    endtask

    // One frame; pix_w of 0 selects random pixel words, abort_at is a pixel index or -1.
    task automatic send_frame(input int gm, input logic [15:0] pix_w, input int abort_at,
                              input bit chg, input logic [1:0] n_mode, input logic [1:0] n_bayer,
                              input logic [3:0] n_shift);
        logic [15:0] w;
        for (int i = 0; i < FH; i++) send_word(16'($urandom), 1'b0, 0, 0, 1'b0, pick_gap(gm));
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < RH; i++) send_word(16'($urandom), 1'b0, 0, 0, 1'b0, pick_gap(gm));
            for (int c = 0; c < COLS; c++) begin
                if (r * COLS + c == abort_at) begin
                    do_abort();
                    return;
                end
                if (chg && r == 0 && c == 1) begin
                    cfg_mode  = n_mode;
                    cfg_bayer = n_bayer;
                    cfg_shift = n_shift;
                end
                w = (pix_w == 16'd0) ? 16'($urandom) : pix_w;
                send_word(w, 1'b1, r, c, 1'b0, pick_gap(gm));
            end
            for (int i = 0; i < RT; i++) send_word(16'($urandom), 1'b0, 0, 0, 1'b0, pick_gap(gm));
        end
        for (int i = 0; i < FT; i++)
            send_word(16'($urandom), 1'b0, 0, 0, (i == FT - 1), pick_gap(gm));
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        bit   exp_done;
        bit   have;
        exp_t e;
        if (checking) begin
            exp_done = 1'b0;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                exp_done = 1'b1;
                void'(done_q.pop_front());
            end
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
            if (out_valid) begin
                seen_q.push_back(out_data);
                have = (exp_q.size() > 0);
                check("pixel_expected", {31'd0, have}, 32'd1);
                if (have) begin
                    e = exp_q.pop_front();
                    check("out_data", {16'd0, out_data}, {16'd0, e.d});
                    check("out_sof", {31'd0, out_sof}, {31'd0, e.sof});
                    check("out_eol", {31'd0, out_eol}, {31'd0, e.eol});
                    check("latency", cyc, e.at);
                    m_pix++;
                end
            end else begin
                check("idle_outputs", {14'd0, out_data, out_sof, out_eol}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                    check("pixel_late", {31'd0, out_valid}, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            if (clr_q.size() > 0 && clr_q[0] == cyc) begin
                void'(clr_q.pop_front());
                m_pix = 0;
            end
            if (exp_done) begin
                m_frames++;
                m_pix = 0;
            end
`ifdef RAW_UNPACK_STATS_EN
            if (exp_done) check("stat_pixels_full_frame", prev_stat_pix, 32'(COLS * ROWS));
            check("stat_frames", {16'd0, stat_frames}, 32'(m_frames % 65536));
            check("stat_pixels", stat_pixels, 32'(m_pix));
            prev_stat_pix = stat_pixels;
`endif
        end
    end

    initial begin
        logic [15:0] tab_a[8];
        logic [15:0] tab_b[8];
        int base;
        tab_a = '{16'hF800, 16'h07E0, 16'hF800, 16'h07E0, 16'h07E0, 16'h001F, 16'h07E0, 16'h001F};
        tab_b = '{16'h001F, 16'h07E0, 16'h001F, 16'h07E0, 16'h07E0, 16'hF800, 16'h07E0, 16'hF800};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; frame_abort = 1'b0;
        cfg_mode = 2'd0; cfg_bayer = 2'd0; cfg_shift = 4'd10;
        latch_model_cfg();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {13'd0, out_valid, out_data, out_sof, out_eol, frame_done}, 32'd0);
`ifdef RAW_UNPACK_STATS_EN
        check("reset_stat_frames", {16'd0, stat_frames}, 32'd0);
        check("reset_stat_pixels", stat_pixels, 32'd0);
`endif
        rst_n = 1'b1;
        checking = 1'b1;

        // Mode 0 / RGGB; bayer changed to BGGR mid-frame, effective next frame.
        base = seen_q.size();
        send_frame(0, 16'hFC00, -1, 1'b1, 2'd0, 2'd3, 4'd10);
        idle(3);
        for (int i = 0; i < 8; i++) check($sformatf("frameA_px%0d", i), {16'd0, seen_q[base + i]}, {16'd0, tab_a[i]});

        base = seen_q.size();
        send_frame(0, 16'hFC00, -1, 1'b1, 2'd1, 2'd3, 4'd10);
        idle(3);
        for (int i = 0; i < 8; i++) check($sformatf("frameB_px%0d", i), {16'd0, seen_q[base + i]}, {16'd0, tab_b[i]});

        base = seen_q.size();
        send_frame(0, 16'h1234, -1, 1'b1, 2'd2, 2'd0, 4'd4);
        idle(3);
        check("mode1_passthrough", {16'd0, seen_q[base]}, 32'h1234);

        base = seen_q.size();
        send_frame(0, 16'h03F0, -1, 1'b1, 2'd0, 2'd0, 4'd10);
        idle(3);
        check("mode2_grey", {16'd0, seen_q[base]}, 32'hFFFF);

        // Alternating in_valid.
        send_frame(1, 16'd0, -1, 1'b0, 2'd0, 2'd0, 4'd0);
        idle(3);

        // Abort at row 1, col 2, then a clean frame.
        base = seen_q.size();
        send_frame(0, 16'd0, 6, 1'b0, 2'd0, 2'd0, 4'd0);
        idle(3);
        check("abort_pixel_count", 32'(seen_q.size() - base), 32'd6);
        base = seen_q.size();
        send_frame(0, 16'd0, -1, 1'b0, 2'd0, 2'd0, 4'd0);
        idle(3);
        check("post_abort_pixel_count", 32'(seen_q.size() - base), 32'd8);

        // Random gaps, configurations and aborts.
        for (int k = 0; k < 8; k++) begin
            send_frame(2, 16'd0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                       1'b1, 2'($urandom), 2'($urandom), 4'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
        idle(4);
        check("pixels_outstanding", 32'(exp_q.size()), 32'd0);
        check("done_outstanding", 32'(done_q.size()), 32'd0);
`ifdef RAW_UNPACK_STATS_EN
        check("stat_frames_final", {16'd0, stat_frames}, 32'(m_frames));
`endif
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
